// File: rtl/pcie_package.sv
`default_nettype none
// ============================================================================
// Package : pcie_package
// Shared PCIe packet-path constants, narrow beat type and lane-mask helper.
// Rev 1.1 : added lane-mask helper for the packet upsizer
// ============================================================================
package pcie_package;

  localparam int PCIE_DATA_W    = 128;
  localparam int PCIE_SLOT_W    = 16;
  localparam int PCIE_MAX_RATIO = 8;

  typedef struct packed {
    logic [PCIE_DATA_W-1:0] data;
    logic                   valid;
    logic                   last;
    logic [PCIE_SLOT_W-1:0] slot;
    logic [13:0]            pad;
  } PCIEPacket;

  // Mask with lanes 0..idx set; callers cast down to their own lane count.
  function automatic logic [PCIE_MAX_RATIO-1:0] keep_from_idx(input logic [2:0] idx);
    logic [PCIE_MAX_RATIO:0] m;
    m = (9'd2 << idx) - 9'd1;
    return m[PCIE_MAX_RATIO-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/pcie_wide_out_reg.sv
`default_nettype none
// ============================================================================
// Module : pcie_wide_out_reg
// Single-entry wide-beat holding register with valid/ready handshake.
// Rev 1.0 : initial release
// ============================================================================
module pcie_wide_out_reg #(
  parameter int WIDE_W = 512,
  parameter int KEEP_W = 4,
  parameter int SLOT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic [WIDE_W-1:0] data_i,
  input  logic [KEEP_W-1:0] keep_i,
  input  logic              last_i,
  input  logic [SLOT_W-1:0] slot_i,
  output logic              free_o,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic [WIDE_W-1:0] m_data_o,
  output logic [KEEP_W-1:0] m_keep_o,
  output logic              m_last_o,
  output logic [SLOT_W-1:0] m_slot_o
);

  logic              valid_q;
  logic [WIDE_W-1:0] data_q;
  logic [KEEP_W-1:0] keep_q;
  logic              last_q;
  logic [SLOT_W-1:0] slot_q;

  // Free when empty or draining this cycle, so a reload can overlap the drain.
  assign free_o = !valid_q || m_ready_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
      slot_q  <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
      keep_q  <= keep_i;
      last_q  <= last_i;
      slot_q  <= slot_i;
    end else if (m_ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign m_valid_o = valid_q;
  assign m_data_o  = data_q;
  assign m_keep_o  = keep_q;
  assign m_last_o  = last_q;
  assign m_slot_o  = slot_q;

endmodule
`default_nettype wire

// File: rtl/pcie_packet_upsizer.sv
`default_nettype none
// ============================================================================
// Module : pcie_packet_upsizer
// Packs RATIO slot-tagged narrow beats into one wide beat with a lane keep mask.
// Rev 1.0 : initial release
// ============================================================================
module pcie_packet_upsizer
  import pcie_package::*;
#(
  parameter int DATA_W = PCIE_DATA_W,
  parameter int RATIO  = 4,
  parameter int SLOT_W = PCIE_SLOT_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [DATA_W-1:0]       s_data,
  input  logic                    s_last,
  input  logic [SLOT_W-1:0]       s_slot,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [RATIO*DATA_W-1:0] m_data,
  output logic [RATIO-1:0]        m_keep,
  output logic                    m_last,
  output logic [SLOT_W-1:0]       m_slot
);

  localparam int                IDX_W    = $clog2(RATIO);
  localparam int                WIDE_W   = RATIO * DATA_W;
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(RATIO - 1);

  logic [RATIO-1:0][DATA_W-1:0] acc_q, acc_d;
  logic [RATIO-1:0]             acc_keep_q, acc_keep_d;
  logic [SLOT_W-1:0]            acc_slot_q, acc_slot_d;
  logic [IDX_W-1:0]             idx_q, idx_d;
  logic                         pend_q, pend_d;
  logic                         rdy_en_q;

  logic                         w_out_free;
  logic                         w_fire;
  logic                         w_flush;
  logic [RATIO-1:0]             w_lane_mask;
  logic [RATIO-1:0]             w_lane_bit;
  logic [RATIO-1:0][DATA_W-1:0] w_word;
  logic [RATIO-1:0][DATA_W-1:0] w_load_data;
  logic                         w_load;
  logic [RATIO-1:0]             w_load_keep;
  logic                         w_load_last;
  logic [SLOT_W-1:0]            w_load_slot;

  assign s_ready     = rdy_en_q && w_out_free;
  assign w_fire      = s_valid && s_ready;
  assign w_lane_mask = RATIO'(keep_from_idx(3'(idx_q)));
  assign w_lane_bit  = RATIO'(1) << idx_q;
  // pend_q marks a held single-beat last that lost the race to a slot flush.
  assign w_flush     = pend_q || ((idx_q != '0) && (s_slot != acc_slot_q));

  generate
    for (genvar i = 0; i < RATIO; i++) begin : g_lane
      localparam logic [IDX_W-1:0] LANE = IDX_W'(i);
      assign w_word[i]      = (LANE == idx_q) ? s_data : acc_q[i];
      assign w_load_data[i] = w_load_keep[i] ? w_word[i] : '0;
    end
  endgenerate

  always_comb begin
    acc_d       = acc_q;
    acc_keep_d  = acc_keep_q;
    acc_slot_d  = acc_slot_q;
    idx_d       = idx_q;
    pend_d      = pend_q;
    w_load      = 1'b0;
    w_load_keep = '0;
    w_load_last = 1'b0;
    w_load_slot = acc_slot_q;
    if (w_fire) begin
      if (w_flush) begin
        w_load      = 1'b1;
        w_load_keep = acc_keep_q;
        w_load_last = pend_q;
        w_load_slot = acc_slot_q;
        acc_d[0]    = s_data;
        acc_keep_d  = RATIO'(1);
        acc_slot_d  = s_slot;
        idx_d       = IDX_W'(1);
        pend_d      = s_last;
      end else if ((idx_q == IDX_LAST) || s_last) begin
        w_load      = 1'b1;
        w_load_keep = w_lane_mask;
        w_load_last = s_last;
        w_load_slot = s_slot;
        acc_keep_d  = '0;
        acc_slot_d  = s_slot;
        idx_d       = '0;
        pend_d      = 1'b0;
      end else begin
        acc_d[idx_q] = s_data;
        acc_keep_d   = acc_keep_q | w_lane_bit;
        acc_slot_d   = s_slot;
        idx_d        = idx_q + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q      <= '0;
      acc_keep_q <= '0;
      acc_slot_q <= '0;
      idx_q      <= '0;
      pend_q     <= 1'b0;
      rdy_en_q   <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      acc_keep_q <= acc_keep_d;
      acc_slot_q <= acc_slot_d;
      idx_q      <= idx_d;
      pend_q     <= pend_d;
      rdy_en_q   <= 1'b1;
    end
  end

  pcie_wide_out_reg #(
    .WIDE_W (WIDE_W),
    .KEEP_W (RATIO),
    .SLOT_W (SLOT_W)
  ) u_out_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (w_load),
    .data_i    (w_load_data),
    .keep_i    (w_load_keep),
    .last_i    (w_load_last),
    .slot_i    (w_load_slot),
    .free_o    (w_out_free),
    .m_valid_o (m_valid),
    .m_ready_i (m_ready),
    .m_data_o  (m_data),
    .m_keep_o  (m_keep),
    .m_last_o  (m_last),
    .m_slot_o  (m_slot)
  );

endmodule
`default_nettype wire

// File: tb/tb_pcie_packet_upsizer.sv
`default_nettype none
// ============================================================================
// Module : tb_pcie_packet_upsizer
// Directed vector table plus reset and randomised scoreboard sequences.
// Rev 1.0 : initial release
// ============================================================================
module tb_pcie_packet_upsizer;

  localparam int DATA_W = 128;
  localparam int RATIO  = 4;
  localparam int SLOT_W = 16;
  localparam int WIDE_W = RATIO * DATA_W;
  localparam int NBEATS = 1000;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              s_valid, s_ready, s_last;
  logic [DATA_W-1:0] s_data;
  logic [SLOT_W-1:0] s_slot;
  logic              m_valid, m_ready, m_last;
  logic [WIDE_W-1:0] m_data;
  logic [RATIO-1:0]  m_keep;
  logic [SLOT_W-1:0] m_slot;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        vld;
    logic [7:0]  tag;
    logic        lst;
    logic [15:0] slot;
    logic        mrdy;
    logic        e_vld;
    logic        e_rdy;
    logic [3:0]  e_keep;
    logic        e_lst;
    logic [15:0] e_slot;
    logic [31:0] e_tags;
  } vec_t;

  vec_t vecs[$];

  logic [15:0] b_slot [NBEATS];
  logic        b_last [NBEATS];
  int          rd;

  always #5 clk = ~clk;

  pcie_packet_upsizer #(
    .DATA_W (DATA_W),
    .RATIO  (RATIO),
    .SLOT_W (SLOT_W)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .s_last  (s_last),
    .s_slot  (s_slot),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_keep  (m_keep),
    .m_last  (m_last),
    .m_slot  (m_slot)
  );

  function automatic void add(input logic vld, input logic [7:0] tag, input logic lst,
                              input logic [15:0] slot, input logic mrdy, input logic e_vld,
                              input logic e_rdy, input logic [3:0] e_keep, input logic e_lst,
                              input logic [15:0] e_slot, input logic [31:0] e_tags);
    vec_t v;
    v.vld = vld; v.tag = tag; v.lst = lst; v.slot = slot; v.mrdy = mrdy;
    v.e_vld = e_vld; v.e_rdy = e_rdy; v.e_keep = e_keep; v.e_lst = e_lst;
    v.e_slot = e_slot; v.e_tags = e_tags;
    vecs.push_back(v);
  endfunction

  function automatic logic [WIDE_W-1:0] word_of(input logic [31:0] tags);
    logic [WIDE_W-1:0] w;
    for (int i = 0; i < RATIO; i++) w[i*DATA_W +: DATA_W] = {16{tags[i*8 +: 8]}};
    return w;
  endfunction

  task automatic chk(input string nm, input logic [WIDE_W-1:0] act, input logic [WIDE_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  task automatic apply(input logic vld, input logic [7:0] tag, input logic lst,
                       input logic [15:0] slot, input logic mrdy);
    @(negedge clk);
    s_valid = vld;
    s_data  = {16{tag}};
    s_last  = lst;
    s_slot  = slot;
    m_ready = mrdy;
    @(posedge clk);
    #1;
  endtask

  task automatic check_wide(input logic [WIDE_W-1:0] d, input logic [3:0] k,
                            input logic l, input logic [15:0] sl);
    int          nk;
    logic        ok;
    logic [127:0] lane;
    ok = 1'b1;
    nk = $countones(k);
    if (nk == 0 || k != 4'((1 << nk) - 1)) ok = 1'b0;
    for (int i = 0; i < RATIO; i++) begin
      lane = d[i*DATA_W +: DATA_W];
      if (i < nk) begin
        if (rd + i >= NBEATS) ok = 1'b0;
        else begin
          if (lane !== {4{32'(rd + i + 1)}}) ok = 1'b0;
          if (sl !== b_slot[rd+i]) ok = 1'b0;
          if (b_last[rd+i] !== ((i == nk - 1) ? l : 1'b0)) ok = 1'b0;
        end
      end else if (lane !== '0) ok = 1'b0;
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL rnd_beat: got keep=%h last=%b slot=%h lane0=%h required first seq %0d slot %h",
               k, l, sl, d[127:0], rd + 1, (rd < NBEATS) ? b_slot[rd] : 16'h0);
    end
    rd += nk;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          wr, cyc, tot, len, slot_cur, ns;
    logic        lst_grp, acc, outv, l_c;
    logic [31:0] sq;
    logic [WIDE_W-1:0] d_c;
    logic [3:0]  k_c;
    logic [15:0] sl_c;

    // Test 1: two full words, second closes the packet
    for (int t = 1; t <= 3; t++) add(1, 8'(t), 0, 16'h5, 1, 0, 1, 4'h0, 0, 16'h0, 32'h0);
    add(1, 8'h04, 0, 16'h5, 1, 1, 1, 4'hF, 0, 16'h5, 32'h04030201);
    for (int t = 5; t <= 7; t++) add(1, 8'(t), 0, 16'h5, 1, 0, 1, 4'h0, 0, 16'h0, 32'h0);
    add(1, 8'h08, 1, 16'h5, 1, 1, 1, 4'hF, 1, 16'h5, 32'h08070605);
    add(0, 8'h00, 0, 16'h0, 1, 0, 1, 4'h0, 0, 16'h0, 32'h0);
    // Test 2: partial word on last
    add(1, 8'h09, 0, 16'h5, 1, 0, 1, 4'h0, 0, 16'h0, 32'h0);
    add(1, 8'h0A, 0, 16'h5, 1, 0, 1, 4'h0, 0, 16'h0, 32'h0);
    add(1, 8'h0B, 1, 16'h5, 1, 1, 1, 4'h7, 1, 16'h5, 32'h000B0A09);
    add(0, 8'h00, 0, 16'h0, 1, 0, 1, 4'h0, 0, 16'h0, 32'h0);
    // Test 3: slot change flush
    add(1, 8'h21, 0, 16'h1, 1, 0, 1, 4'h0, 0, 16'h0, 32'h0);
    add(1, 8'h22, 0, 16'h1, 1, 0, 1, 4'h0, 0, 16'h0, 32'h0);
    add(1, 8'h23, 0, 16'h2, 1, 1, 1, 4'h3, 0, 16'h1, 32'h00002221);
    add(1, 8'h24, 1, 16'h2, 1, 1, 1, 4'h3, 1, 16'h2, 32'h00002423);
    add(0, 8'h00, 0, 16'h0, 1, 0, 1, 4'h0, 0, 16'h0, 32'h0);
    // Flush colliding with a single-beat last: that beat waits for the next one
    add(1, 8'h31, 0, 16'h1, 1, 0, 1, 4'h0, 0, 16'h0, 32'h0);
    add(1, 8'h32, 0, 16'h1, 1, 0, 1, 4'h0, 0, 16'h0, 32'h0);
    add(1, 8'h33, 1, 16'h3, 1, 1, 1, 4'h3, 0, 16'h1, 32'h00003231);
    add(1, 8'h34, 1, 16'h4, 1, 1, 1, 4'h1, 1, 16'h3, 32'h00000033);
    add(1, 8'h35, 0, 16'h4, 1, 1, 1, 4'h1, 1, 16'h4, 32'h00000034);
    add(1, 8'h36, 1, 16'h4, 1, 1, 1, 4'h3, 1, 16'h4, 32'h00003635);
    add(0, 8'h00, 0, 16'h0, 1, 0, 1, 4'h0, 0, 16'h0, 32'h0);
    // Test 4: back-pressure for 10 cycles
    add(1, 8'h41, 0, 16'h6, 1, 0, 1, 4'h0, 0, 16'h0, 32'h0);
    add(1, 8'h42, 0, 16'h6, 1, 0, 1, 4'h0, 0, 16'h0, 32'h0);
    add(1, 8'h43, 0, 16'h6, 1, 0, 1, 4'h0, 0, 16'h0, 32'h0);
    add(1, 8'h44, 0, 16'h6, 1, 1, 1, 4'hF, 0, 16'h6, 32'h44434241);
    for (int t = 0; t < 10; t++) add(1, 8'h45, 0, 16'h6, 0, 1, 0, 4'hF, 0, 16'h6, 32'h44434241);
    add(1, 8'h45, 0, 16'h6, 1, 0, 1, 4'h0, 0, 16'h0, 32'h0);
    add(1, 8'h46, 0, 16'h6, 1, 0, 1, 4'h0, 0, 16'h0, 32'h0);
    add(1, 8'h47, 0, 16'h6, 1, 0, 1, 4'h0, 0, 16'h0, 32'h0);
    add(1, 8'h48, 1, 16'h6, 1, 1, 1, 4'hF, 1, 16'h6, 32'h48474645);
    add(0, 8'h00, 0, 16'h0, 1, 0, 1, 4'h0, 0, 16'h0, 32'h0);

    // Reset state
    rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; s_slot = '0; m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_valid", WIDE_W'(m_valid), '0);
    chk("rst_m_data",  m_data, '0);
    chk("rst_m_keep",  WIDE_W'(m_keep), '0);
    chk("rst_m_last",  WIDE_W'(m_last), '0);
    chk("rst_m_slot",  WIDE_W'(m_slot), '0);
    chk("rst_s_ready", WIDE_W'(s_ready), '0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_s_ready_pre_edge", WIDE_W'(s_ready), '0);
    @(posedge clk);
    #1;
    chk("rel_s_ready_post_edge", WIDE_W'(s_ready), WIDE_W'(1'b1));

    for (int j = 0; j < vecs.size(); j++) begin
      apply(vecs[j].vld, vecs[j].tag, vecs[j].lst, vecs[j].slot, vecs[j].mrdy);
      chk($sformatf("v%0d_m_valid", j), WIDE_W'(m_valid), WIDE_W'(vecs[j].e_vld));
      chk($sformatf("v%0d_s_ready", j), WIDE_W'(s_ready), WIDE_W'(vecs[j].e_rdy));
      if (vecs[j].e_vld) begin
        chk($sformatf("v%0d_m_keep", j), WIDE_W'(m_keep), WIDE_W'(vecs[j].e_keep));
        chk($sformatf("v%0d_m_last", j), WIDE_W'(m_last), WIDE_W'(vecs[j].e_lst));
        chk($sformatf("v%0d_m_slot", j), WIDE_W'(m_slot), WIDE_W'(vecs[j].e_slot));
        chk($sformatf("v%0d_m_data", j), m_data, word_of(vecs[j].e_tags));
      end
    end

    // Test 5: asynchronous reset mid-packet, then with a held output word
    apply(1, 8'h51, 0, 16'h7, 1);
    apply(1, 8'h52, 0, 16'h7, 1);
    @(negedge clk);
    s_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("r5a_m_valid", WIDE_W'(m_valid), '0);
    chk("r5a_s_ready", WIDE_W'(s_ready), '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    apply(1, 8'h61, 0, 16'h7, 1);
    apply(1, 8'h62, 0, 16'h7, 1);
    apply(1, 8'h63, 0, 16'h7, 1);
    chk("r5b_no_early_word", WIDE_W'(m_valid), '0);
    apply(1, 8'h64, 0, 16'h7, 1);
    chk("r5b_m_valid", WIDE_W'(m_valid), WIDE_W'(1'b1));
    chk("r5b_m_keep",  WIDE_W'(m_keep), WIDE_W'(4'hF));
    chk("r5b_m_data",  m_data, word_of(32'h64636261));
    @(negedge clk);
    s_valid = 1'b0;
    m_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("r5c_m_valid", WIDE_W'(m_valid), '0);
    chk("r5c_m_data",  m_data, '0);
    chk("r5c_m_keep",  WIDE_W'(m_keep), '0);
    chk("r5c_m_slot",  WIDE_W'(m_slot), '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Test 6: random traffic against a scoreboard
    tot = 0;
    slot_cur = 0;
    while (tot < NBEATS - 2) begin
      len = $urandom_range(1, 9);
      do ns = $urandom_range(1, 4); while (ns == slot_cur);
      slot_cur = ns;
      lst_grp = 1'($urandom_range(0, 1));
      for (int k = 0; k < len && tot < NBEATS - 2; k++) begin
        b_slot[tot] = 16'(ns);
        b_last[tot] = (k == len - 1) && lst_grp;
        tot++;
      end
    end
    do ns = $urandom_range(1, 4); while (ns == slot_cur);
    b_slot[NBEATS-2] = 16'(ns); b_last[NBEATS-2] = 1'b0;
    b_slot[NBEATS-1] = 16'(ns); b_last[NBEATS-1] = 1'b1;

    wr = 0;
    rd = 0;
    cyc = 0;
    while (rd < NBEATS && cyc < 20000) begin
      @(negedge clk);
      m_ready = 1'($urandom_range(0, 1));
      if (wr < NBEATS && $urandom_range(0, 1) == 1) begin
        sq      = 32'(wr + 1);
        s_valid = 1'b1;
        s_data  = {4{sq}};
        s_slot  = b_slot[wr];
        s_last  = b_last[wr];
      end else begin
        s_valid = 1'b0;
      end
      #1;
      acc  = s_valid && s_ready;
      outv = m_valid && m_ready;
      d_c  = m_data;
      k_c  = m_keep;
      l_c  = m_last;
      sl_c = m_slot;
      @(posedge clk);
      if (acc) wr++;
      if (outv) check_wide(d_c, k_c, l_c, sl_c);
      cyc++;
    end
    chk("rnd_beats_sent", WIDE_W'(wr), WIDE_W'(NBEATS));
    chk("rnd_beats_received", WIDE_W'(rd), WIDE_W'(NBEATS));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
